// File: rtl/best_move_selector.sv
// rtl/best_move_selector.sv - sums per-direction scores per cell and tracks the best cell of a scan
// IDLE -> ACCUM on start, ACCUM -> DONE on in_last, DONE -> IDLE after a one-cycle done pulse.
module best_move_selector #(
   parameter int DIRS    = 4,
   parameter int SCORE_W = 13,
   parameter int SUM_W   = 16,
   parameter int COORD_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SCORE_W-1:0] in_score,
   input  logic [COORD_W-1:0] in_row,
   input  logic [COORD_W-1:0] in_col,
   input  logic               in_last,
   output logic               busy,
   output logic               done,
   output logic               best_valid,
   output logic [COORD_W-1:0] best_row,
   output logic [COORD_W-1:0] best_col,
   output logic [SUM_W-1:0]   best_score,
   output logic               proto_err
);

   localparam int CNT_W = (DIRS > 1) ? $clog2(DIRS) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_dir_cnt;
   logic [SUM_W-1:0]   r_acc;
   logic [COORD_W-1:0] r_cur_row;
   logic [COORD_W-1:0] r_cur_col;
   logic               r_done;
   logic               r_best_valid;
   logic [COORD_W-1:0] r_best_row;
   logic [COORD_W-1:0] r_best_col;
   logic [SUM_W-1:0]   r_best_score;
   logic               r_proto_err;

   logic               w_accum;
   logic               w_accept;
   logic               w_first;
   logic               w_final;
   logic [SUM_W-1:0]   w_score_ext;
   logic [SUM_W-1:0]   w_total;

   assign w_accum     = (r_state == S_ACCUM);
   assign in_ready    = w_accum;
   assign busy        = w_accum;
   // a start pulse in ACCUM restarts the scan, so any beat presented with it is dropped
   assign w_accept    = w_accum & in_valid & ~start;
   assign w_first     = (r_dir_cnt == '0);
   assign w_final     = (r_dir_cnt == CNT_W'(DIRS - 1));
   assign w_score_ext = {{(SUM_W - SCORE_W){1'b0}}, in_score};
   assign w_total     = r_acc + w_score_ext;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_dir_cnt    <= '0;
         r_acc        <= '0;
         r_cur_row    <= '0;
         r_cur_col    <= '0;
         r_done       <= 1'b0;
         r_best_valid <= 1'b0;
         r_best_row   <= '0;
         r_best_col   <= '0;
         r_best_score <= '0;
         r_proto_err  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_acc        <= '0;
                  r_dir_cnt    <= '0;
                  r_best_valid <= 1'b0;
                  r_best_score <= '0;
                  r_best_row   <= '0;
                  r_best_col   <= '0;
                  r_proto_err  <= 1'b0;
                  r_state      <= S_ACCUM;
               end
            end
            S_ACCUM: begin
               if (start) begin
                  r_acc        <= '0;
                  r_dir_cnt    <= '0;
                  r_best_valid <= 1'b0;
                  r_best_score <= '0;
                  r_best_row   <= '0;
                  r_best_col   <= '0;
                  r_proto_err  <= 1'b0;
               end else if (w_accept) begin
                  if (in_last && !w_final) begin
                     // truncated cell: its partial sum never competes
                     r_proto_err <= 1'b1;
                     r_dir_cnt   <= '0;
                     r_acc       <= '0;
                     r_done      <= 1'b1;
                     r_state     <= S_DONE;
                  end else if (w_final) begin
                     if (w_total > r_best_score) begin
                        r_best_score <= w_total;
                        r_best_row   <= r_cur_row;
                        r_best_col   <= r_cur_col;
                        r_best_valid <= 1'b1;
                     end
                     r_dir_cnt <= '0;
                     if (in_last) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                     end
                  end else begin
                     if (w_first) begin
                        r_cur_row <= in_row;
                        r_cur_col <= in_col;
                        r_acc     <= w_score_ext;
                     end else begin
                        r_acc <= w_total;
                     end
                     r_dir_cnt <= r_dir_cnt + CNT_W'(1);
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign done       = r_done;
   assign best_valid = r_best_valid;
   assign best_row   = r_best_row;
   assign best_col   = r_best_col;
   assign best_score = r_best_score;
   assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_best_move_selector.sv
// tb/tb_best_move_selector.sv - directed and randomized scans checked against a per-cell reference model
module tb_best_move_selector;

   localparam int DIRS    = 4;
   localparam int SCORE_W = 13;
   localparam int SUM_W   = 16;
   localparam int COORD_W = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               in_valid;
   logic               in_ready;
   logic [SCORE_W-1:0] in_score;
   logic [COORD_W-1:0] in_row;
   logic [COORD_W-1:0] in_col;
   logic               in_last;
   logic               busy;
   logic               done;
   logic               best_valid;
   logic [COORD_W-1:0] best_row;
   logic [COORD_W-1:0] best_col;
   logic [SUM_W-1:0]   best_score;
   logic               proto_err;

   int total_n = 0;
   int bad_n   = 0;

   int cs[16][DIRS];
   int cr[16];
   int cc[16];

   always #5 clk = ~clk;

   best_move_selector #(
      .DIRS(DIRS), .SCORE_W(SCORE_W), .SUM_W(SUM_W), .COORD_W(COORD_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_score(in_score),
      .in_row(in_row), .in_col(in_col), .in_last(in_last),
      .busy(busy), .done(done), .best_valid(best_valid),
      .best_row(best_row), .best_col(best_col), .best_score(best_score),
      .proto_err(proto_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_n++;
      assert (obs === exp) else begin
         bad_n++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_in_ready"}, 32'(in_ready), 0);
      chk({tag, "_best_valid"}, 32'(best_valid), 0);
      chk({tag, "_best_row"}, 32'(best_row), 0);
      chk({tag, "_best_col"}, 32'(best_col), 0);
      chk({tag, "_best_score"}, 32'(best_score), 0);
      chk({tag, "_proto_err"}, 32'(proto_err), 0);
   endtask

   // Reference: first strictly-greater complete cell wins; zero totals never count.
   task automatic ref_best(input int n, output int eb, output int er, output int ec, output int ev);
      eb = 0; er = 0; ec = 0; ev = 0;
      for (int i = 0; i < n; i++) begin
         int tot;
         tot = 0;
         for (int d = 0; d < DIRS; d++) tot += cs[i][d];
         if (tot > eb) begin
            eb = tot; er = cr[i]; ec = cc[i]; ev = 1;
         end
      end
   endtask

   task automatic set_cell(input int i, input int r, input int c,
                           input int s0, input int s1, input int s2, input int s3);
      cr[i] = r; cc[i] = c;
      cs[i][0] = s0; cs[i][1] = s1; cs[i][2] = s2; cs[i][3] = s3;
   endtask

   task automatic fill_random(input int n, input int maxs);
      for (int i = 0; i < n; i++) begin
         bit occ;
         occ = ($urandom_range(0, 3) == 0);
         cr[i] = $urandom_range(0, 14);
         cc[i] = $urandom_range(0, 14);
         for (int d = 0; d < DIRS; d++) cs[i][d] = occ ? 0 : $urandom_range(0, maxs);
      end
   endtask

   // Start pulse with a junk beat alongside; it must never be consumed.
   task automatic pulse_start();
      start    = 1'b1;
      in_valid = 1'b1;
      in_score = 13'h1fff;
      in_row   = 4'hf;
      in_col   = 4'hf;
      in_last  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic send_cell(input int i, input int nbeats, input bit last, input bit gaps);
      for (int d = 0; d < nbeats; d++) begin
         int waited;
         if (gaps) begin
            in_valid = 1'b0;
            in_score = SCORE_W'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         waited = 0;
         while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
         end
         if (waited >= 20) chk("in_ready_timeout", 32'(in_ready), 1);
         if (d == 0) chk("busy_in_scan", 32'(busy), 1);
         in_valid = 1'b1;
         in_score = SCORE_W'(cs[i][d]);
         in_row   = (d == 0) ? COORD_W'(cr[i]) : COORD_W'($urandom);
         in_col   = (d == 0) ? COORD_W'(cc[i]) : COORD_W'($urandom);
         in_last  = last && (d == nbeats - 1);
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic run_scan(input string tag, input int n, input int partial, input bit gaps);
      int eb, er, ec, ev;
      pulse_start();
      for (int i = 0; i < n; i++) send_cell(i, DIRS, (i == n - 1) && (partial == 0), gaps);
      if (partial > 0) send_cell(n, partial, 1'b1, gaps);
      in_valid = 1'b0;
      in_last  = 1'b0;
      ref_best(n, eb, er, ec, ev);
      chk({tag, "_done"}, 32'(done), 1);
      chk({tag, "_in_ready_done"}, 32'(in_ready), 0);
      chk({tag, "_busy_done"}, 32'(busy), 0);
      chk({tag, "_best_valid"}, 32'(best_valid), 32'(ev));
      chk({tag, "_best_row"}, 32'(best_row), 32'(er));
      chk({tag, "_best_col"}, 32'(best_col), 32'(ec));
      chk({tag, "_best_score"}, 32'(best_score), 32'(eb));
      chk({tag, "_proto_err"}, 32'(proto_err), (partial > 0) ? 1 : 0);
      // beats offered in DONE and IDLE must be ignored
      in_valid = 1'b1;
      in_score = 13'd8000;
      in_last  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk({tag, "_done_after"}, 32'(done), 0);
         chk({tag, "_in_ready_idle"}, 32'(in_ready), 0);
      end
      chk({tag, "_hold_score"}, 32'(best_score), 32'(eb));
      chk({tag, "_hold_proto"}, 32'(proto_err), (partial > 0) ? 1 : 0);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_score = '0;
      in_row = '0; in_col = '0; in_last = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // reset mid-scan: 5 beats then reset
      set_cell(0, 3, 4, 100, 200, 300, 400);
      set_cell(1, 5, 6, 900, 0, 0, 0);
      pulse_start();
      send_cell(0, DIRS, 1'b0, 1'b0);
      send_cell(1, 1, 1'b0, 1'b0);
      in_valid = 1'b0;
      chk("pre_reset_best", 32'(best_score), 1000);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_all_zero("mid_reset");
      repeat (3) begin
         @(negedge clk);
         chk("mid_reset_no_done", 32'(done), 0);
         chk("mid_reset_idle", 32'(busy), 0);
      end

      // three-cell directed scan, gapless then with gaps
      set_cell(0, 2, 3, 1, 1, 8, 2);
      set_cell(1, 7, 7, 40, 1, 1, 2);
      set_cell(2, 0, 0, 0, 0, 0, 0);
      run_scan("basic", 3, 0, 1'b0);
      chk("basic_row7", 32'(best_row), 7);
      chk("basic_score44", 32'(best_score), 44);
      run_scan("basic_gaps", 3, 0, 1'b1);
      chk("basic_gaps_score44", 32'(best_score), 44);

      // tie keeps the earlier cell
      set_cell(0, 1, 1, 100, 100, 50, 50);
      set_cell(1, 5, 9, 75, 75, 75, 75);
      run_scan("tie", 2, 0, 1'b0);
      chk("tie_row1", 32'(best_row), 1);
      chk("tie_col1", 32'(best_col), 1);

      // all-occupied scan
      for (int i = 0; i < 4; i++) set_cell(i, i + 1, i + 2, 0, 0, 0, 0);
      run_scan("occupied", 4, 0, 1'b0);

      // in_last on the 2nd beat of a cell; partial cell would have won
      set_cell(0, 4, 4, 10, 10, 10, 20);
      set_cell(1, 9, 9, 3000, 3000, 0, 0);
      run_scan("proto", 1, 2, 1'b0);

      // next start clears proto_err
      set_cell(0, 6, 2, 5, 5, 5, 5);
      run_scan("proto_clear", 1, 0, 1'b1);

      // start mid-ACCUM wipes a recorded best of 2000
      set_cell(0, 12, 13, 500, 500, 500, 500);
      pulse_start();
      send_cell(0, DIRS, 1'b0, 1'b0);
      in_valid = 1'b0;
      chk("restart_pre_best", 32'(best_score), 2000);
      set_cell(0, 3, 3, 1, 2, 3, 4);
      set_cell(1, 8, 1, 7, 0, 0, 0);
      run_scan("restart", 2, 0, 1'b0);
      chk("restart_score10", 32'(best_score), 10);

      // randomized scans; small score ranges provoke ties
      for (int t = 0; t < 8; t++) begin
         int n;
         n = $urandom_range(1, 10);
         fill_random(n, (t % 2 == 0) ? 3 : 8191);
         run_scan($sformatf("rand%0d", t), n, (t == 5) ? 3 : 0, t[0]);
      end

      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end

endmodule

// File: doc/best_move_selector.md
Name: best_move_selector

Overview:
- Downstream consumer of the per-direction line-pattern scorer.
- Per candidate cell it receives DIRS successive 13-bit direction scores and sums them into a cell total. It tracks the maximum-total cell over one board scan and reports the best move coordinates and score when the scan ends.
- Sits between the scorer (fed by the board/window scan controller) and the game-control FSM that places the AI stone.

Parameters:
- DIRS, 4, direction scores per cell (horizontal, vertical, two diagonals); must be at least 2.
- SCORE_W, 13, width of one direction score.
- SUM_W, 16, width of cell total and best_score; must be at least SCORE_W + clog2(DIRS), so no overflow is possible.
- COORD_W, 4, width of row and column coordinates (15x15 board).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new scan.
- in_valid  in  1  direction score beat valid.
- in_ready  out  1  block accepts a beat; beat transfers when in_valid and in_ready are both high.
- in_score  in  SCORE_W  one direction score (0 = cell occupied).
- in_row  in  COORD_W  row of current cell; sampled on first beat of cell only.
- in_col  in  COORD_W  column of current cell; sampled on first beat of cell only.
- in_last  in  1  marks the final beat of the final cell of the scan.
- busy  out  1  high while in ACCUM.
- done  out  1  one-cycle pulse at scan completion.
- best_valid  out  1  at least one cell with nonzero total was seen in the last scan.
- best_row  out  COORD_W  row of best cell.
- best_col  out  COORD_W  column of best cell.
- best_score  out  SUM_W  total of best cell.
- proto_err  out  1  sticky until next start; in_last arrived mid-cell.

Behaviour:
- Reset (sync, rst=1 at clk edge): state IDLE; all outputs 0; dir_cnt=0; acc=0. Reset mid-scan aborts the scan; no done is produced.
- States: IDLE, ACCUM, DONE.
- IDLE: in_ready=0. On start: clear acc, dir_cnt, best_valid, best_score, best_row, best_col and proto_err; go to ACCUM next cycle.
- ACCUM: in_ready=1, busy=1. Each accepted beat:
  - First beat (dir_cnt=0): latch in_row/in_col into cur_row/cur_col; acc <= in_score.
  - Middle beats: acc <= acc + in_score; dir_cnt increments.
  - Final beat (dir_cnt=DIRS-1): total = acc + in_score, computed combinationally and zero-extended to SUM_W. At the same edge, if total > best_score (strictly greater), then best_score <= total, best_row/best_col <= cur_row/cur_col, best_valid <= 1. dir_cnt <= 0.
- Tie-break: equal totals keep the earlier cell. Total 0 (occupied cell) never updates, because best_score starts at 0.
- in_last on a final beat: best update applies as above at the same edge; state goes to DONE.
- in_last with dir_cnt != DIRS-1: partial cell is discarded (no best update); proto_err <= 1; state goes to DONE.
- in_valid=0 cycles (gaps): acc, dir_cnt and state hold.
- DONE: in_ready=0, busy=0, done=1 for exactly one cycle; next state IDLE. best_* and proto_err hold until the next start.
- start while in ACCUM: restart. Clear as in IDLE and stay in ACCUM; a beat presented in that cycle is ignored (not accepted).
- start while in DONE: ignored.
- Latency: done asserts 1 cycle after the in_last beat is accepted; best_* are already final in that cycle.
- All outputs registered except in_ready and busy, which decode from the state register.

Test Plan:
- Reset mid-scan: start, 5 beats, rst for 1 cycle -> state IDLE, done never pulses, all outputs 0.
- Single scan of 3 cells, DIRS=4:
  - (2,3) scores 1,1,8,2 (total 12); (7,7) scores 40,1,1,2 (total 44); (0,0) scores 0,0,0,0.
  - -> done one cycle after last beat; best_row=7, best_col=7, best_score=44, best_valid=1, proto_err=0.
- Tie: (1,1) totals 300 and (5,9) totals 300, in that order -> best_row=1, best_col=1, best_score=300.
- All-occupied scan (every score 0, 4 cells) -> done, best_valid=0, best_score=0.
- Back-pressure and gaps:
  - random in_valid gaps -> same result as the gapless case.
  - in_ready=0 in IDLE and DONE; beats offered there are not consumed.
- Protocol error and restart:
  - in_last on the 2nd beat of a cell -> partial cell discarded, proto_err=1, done pulse.
  - Next start clears proto_err.
  - start mid-ACCUM clears a previously recorded best of 2000.
